// File: rtl/otter_mem_pkg.sv
// Shared definitions for the OTTER burst memory responder.
// Also supplies the burst defaults used by the cache line adapter.
package otter_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WCAP,
        WAIT,
        RBURST,
        WACK
    } mem_state_t;

    localparam int unsigned MEM_DELAY_CYCLES = 10;
    localparam int unsigned MEM_BURST_LEN    = 4;

    // Clears the beat-offset bits of a word index.
    function automatic logic [31:0] burst_mask(int unsigned blen);
        return ~(32'(blen) - 32'd1);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM: synchronous write, registered read.
// Contents are never cleared; there is no reset.
module mem_word_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16384,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write on demand; the read port registers the old word every cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/burst_delay_memory.sv
// Burst main-memory responder with a fixed access latency.
// One burst read or write in flight; requests outside IDLE are dropped.
module burst_delay_memory
    import otter_mem_pkg::*;
#(
    parameter int DELAY_CYCLES = MEM_DELAY_CYCLES,
    parameter int BURST_LEN    = MEM_BURST_LEN,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WORDS   = 16384
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RE,
    input  logic                  WE,
    input  logic [31:0]           ADDR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  MEMVALID
);

    localparam int IW = $clog2(ADDR_WORDS);
    localparam int BW = $clog2(BURST_LEN);
    localparam int CW = $clog2(DELAY_CYCLES + 1);
    localparam logic [31:0] BASE_MASK = burst_mask(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(DELAY_CYCLES - 1);

    mem_state_t             state;
    logic                   is_write;
    logic [IW-BW-1:0]       base_hi;
    logic [BW-1:0]          beat;
    logic [CW-1:0]          cnt;

    logic [IW-1:0]          req_idx;
    logic [IW-1:0]          req_base;
    logic                   ram_we;
    logic [IW-1:0]          ram_addr;
    logic [DATA_WIDTH-1:0]  ram_q;
    logic                   unused_addr;

    assign req_idx     = ADDR[2 +: IW];
    assign req_base    = req_idx & BASE_MASK[IW-1:0];
    assign unused_addr = ^{ADDR[31:2+IW], ADDR[1:0]};

    // RAM port: write beats as captured, otherwise read one beat ahead.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = {base_hi, beat};
        unique case (state)
            IDLE: begin
                ram_we   = WE;
                ram_addr = req_base;
            end
            WCAP: begin
                ram_we   = 1'b1;
                ram_addr = {base_hi, beat};
            end
            WAIT: begin
                ram_addr = {base_hi, {BW{1'b0}}};
            end
            RBURST: begin
                ram_addr = {base_hi, beat + BW'(1)};
            end
            WACK: begin
                ram_addr = {base_hi, beat};
            end
            default: begin
                ram_addr = {base_hi, beat};
            end
        endcase
    end

    mem_word_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (ADDR_WORDS)
    ) u_array (
        .clk  (CLK),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(DATA_IN),
        .rdata(ram_q)
    );

    // Request sequencing: capture, latency count, beats, acknowledge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            is_write <= 1'b0;
            base_hi  <= '0;
            beat     <= '0;
            cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (WE) begin
                        base_hi  <= req_base[IW-1:BW];
                        is_write <= 1'b1;
                        beat     <= BW'(1);
                        state    <= WCAP;
                    end else if (RE) begin
                        base_hi  <= req_base[IW-1:BW];
                        is_write <= 1'b0;
                        beat     <= '0;
                        cnt      <= '0;
                        state    <= WAIT;
                    end
                end
                WCAP: begin
                    if (beat == LAST_BEAT) begin
                        beat  <= '0;
                        cnt   <= '0;
                        state <= WAIT;
                    end else begin
                        beat <= beat + BW'(1);
                    end
                end
                WAIT: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        beat  <= '0;
                        state <= is_write ? WACK : RBURST;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RBURST: begin
                    if (beat == LAST_BEAT) begin
                        beat  <= '0;
                        state <= IDLE;
                    end else begin
                        beat <= beat + BW'(1);
                    end
                end
                WACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign MEMVALID = (state == RBURST) || (state == WACK);
    assign DATA_OUT = (state == RBURST) ? ram_q : '0;

endmodule

// File: tb/tb_burst_delay_memory.sv
// Scoreboard bench for burst_delay_memory with default parameters.
// Stimulus pushes expected beats; the monitor pops on MEMVALID.
module tb_burst_delay_memory;

    localparam int D = 10;
    localparam int B = 4;

    typedef struct {
        int          edge_no;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re  = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] din  = '0;
    logic [31:0] dout;
    logic        mv;

    int   ecnt   = 0;
    int   total  = 0;
    int   passed = 0;
    exp_t sb[$];

    burst_delay_memory dut (
        .CLK     (clk),
        .RST     (rst),
        .RE      (re),
        .WE      (we),
        .ADDR    (addr),
        .DATA_IN (din),
        .DATA_OUT(dout),
        .MEMVALID(mv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic check(input string name, input logic ok,
                         input logic [63:0] act, input logic [63:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Monitor: outputs presented after the last edge, sampled at the next.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (mv === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_memvalid", 1'b0, 64'(ecnt + 1), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", dout === e.data, 64'(dout), 64'(e.data));
                    check("beat_edge", (ecnt + 1) == e.edge_no,
                          64'(ecnt + 1), 64'(e.edge_no));
                end
            end else begin
                check("idle_outputs", mv === 1'b0 && dout === 32'd0,
                      {31'd0, mv, dout}, 64'd0);
            end
        end
    end

    task automatic issue_write(input logic [31:0] a, input logic [3:0][31:0] d,
                               input logic also_re);
        exp_t e;
        @(negedge clk);
        we   = 1'b1;
        re   = also_re;
        addr = a;
        din  = d[0];
        e.edge_no = ecnt + 1 + B + D;
        e.data    = 32'd0;
        sb.push_back(e);
        for (int i = 1; i < B; i++) begin
            @(negedge clk);
            we  = 1'b0;
            re  = 1'b0;
            din = d[i];
        end
        @(negedge clk);
        din = 32'd0;
    endtask

    task automatic issue_read(input logic [31:0] a, input logic [3:0][31:0] d,
                              output int e0);
        exp_t e;
        @(negedge clk);
        re   = 1'b1;
        addr = a;
        e0   = ecnt + 1;
        for (int i = 0; i < B; i++) begin
            e.edge_no = e0 + D + 1 + i;
            e.data    = d[i];
            sb.push_back(e);
        end
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic drain(input string name);
        #1;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check(name, sb.size() == 0, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    logic [3:0][31:0] wa, wb, wc;
    int e0;

    initial begin
        wa = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        wb = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        wc = {32'hC3, 32'hC2, 32'hC1, 32'hC0};

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", mv === 1'b0 && dout === 32'd0,
              {31'd0, mv, dout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        issue_write(32'h100, wa, 1'b0);
        drain("write_a_done");

        issue_read(32'h10C, wa, e0);
        drain("read_unaligned_done");

        issue_write(32'h200, wb, 1'b1);
        drain("we_re_priority_done");
        issue_read(32'h200, wb, e0);
        drain("read_b_done");

        issue_read(32'h100, wa, e0);
        repeat (3) @(negedge clk);
        re   = 1'b1;
        we   = 1'b1;
        addr = 32'h100;
        din  = 32'hDEAD;
        @(negedge clk);
        re  = 1'b0;
        we  = 1'b0;
        din = 32'd0;
        while (ecnt < e0 + 11) @(negedge clk);
        re   = 1'b1;
        addr = 32'h200;
        @(negedge clk);
        re = 1'b0;
        drain("ignored_requests_done");
        repeat (20) @(negedge clk);
        issue_read(32'h100, wa, e0);
        drain("no_stray_write_done");

        issue_read(32'h200, wb, e0);
        while (ecnt < e0 + 11) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_memvalid", mv === 1'b0, 64'(mv), 64'd0);
        check("async_rst_data", dout === 32'd0, 64'(dout), 64'd0);
        check("beats_before_rst", sb.size() == 2, 64'(sb.size()), 64'd2);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        issue_read(32'h200, wb, e0);
        drain("read_after_rst_done");

        issue_write(32'h0, wc, 1'b0);
        drain("write_c_done");
        issue_read(32'h0001_0000, wc, e0);
        drain("wrap_read_done");

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
